som_bmu_search: RTL and testbench
=================================

// Module: som_bmu_search
// PURPOSE
//  Best-matching-unit finder downstream of the SOM controller. Latches the 16
//  neuron distances on op_wr, then runs a 4-stage pairwise tournament (16->8->4->2->1),
//  advancing one stage per cycle under the controller's one-hot compare_en.
//  Presents the winning neuron index and distance to the weight-update and map-write
//  stages. The result is valid in the cycle the controller enters UPDATE or MAP.
// PARAMETERS
//  DW  20  distance width in bits (unsigned)
//  IW  4   neuron index width; fixed at 4 (16 neurons, 4 stages, matches compare_en)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       async reset, ACTIVE-LOW (asserted when 0)
//  op_wr       in   1       load dist_in into the tournament registers
//  dist_in     in   16*DW   neuron distances, neuron k at [k*DW +: DW]
//  compare_en  in   4       one-hot stage strobe: 1000=s0, 0100=s1, 0010=s2, 0001=s3
//  bmu_valid   out  1       1-cycle pulse: new winner on bmu_idx/bmu_dist
//  bmu_idx     out  IW      winning neuron index, held until the next winner
//  bmu_dist    out  DW      winning distance, held until the next winner
//  busy        out  1       high from the op_wr load until the s3 reduction
//  seq_err     out  1       sticky: an out-of-order compare_en was seen
// BEHAVIOUR
//  Reset (rst==0, async): all outputs 0, stage counter 0, candidate registers 0.
//  State: IDLE (busy=0) or RUN (busy=1), plus a 2-bit expected-stage counter exp_stg.
//  op_wr=1, any state, on a clock edge:
//   - load 16 candidates {idx=k, dist=dist_in[k]};
//   - exp_stg<=0, go to RUN, busy<=1;
//   - op_wr has priority over a same-cycle compare_en (that strobe is dropped, no error).
//  RUN, compare_en == onehot(exp_stg):
//   - reduce pair (2j, 2j+1) into slot j;
//   - winner = (dist[2j] <= dist[2j+1]) ? slot 2j : slot 2j+1, so ties go to the lower index;
//   - slot count halves: 16->8->4->2->1;
//   - exp_stg increments.
//  s3 reduction edge:
//   - bmu_idx/bmu_dist <= final candidate; bmu_valid<=1 for exactly one cycle;
//   - busy<=0, go to IDLE.
//  Latency: op_wr at edge E, strobes at edges E+1..E+4, bmu_valid high after E+4.
//   With the controller's OP->COMPARE x4->UPDATE sequence, bmu_valid is high during UPDATE.
//  compare_en==0: hold all state; gaps between stages are allowed.
//  Ignored with seq_err<=1: compare_en nonzero and not onehot(exp_stg) in RUN;
//   compare_en nonzero while IDLE; compare_en not one-hot.
//  seq_err clears only on reset.
//  Arithmetic: unsigned compare, full DW bits, no saturation; dist all-ones is a legal value.
//  Reset mid-operation aborts the search; bmu_valid never fires for the aborted load.
//  bmu_idx/bmu_dist change only on a bmu_valid cycle or on reset.
// TESTING
//  1 Reset: rst=0 mid-RUN -> all outputs 0 at once; after release, no bmu_valid without op_wr.
//  2 Single minimum: dist[k]=100+k, dist[9]=3; op_wr, 4 strobes ->
//    bmu_valid 1 cycle after 4th strobe, bmu_idx=9, bmu_dist=3.
//  3 Ties: all dist=50 -> bmu_idx=0. Only dist[6]=dist[13]=7, others max -> bmu_idx=6.
//  4 Width edge: all dist=2^DW-1 except dist[15]=2^DW-2 -> bmu_idx=15.
//  5 Gaps and misorder: idle cycles between strobes give the same result as back-to-back;
//    0010 issued before 0100 -> seq_err=1, strobe ignored, correct 0100 then continues.
//  6 Back-to-back: op_wr in the s3 cycle drops the strobe; next 4 strobes give the new winner;
//    previous bmu_idx is held meanwhile.

Source files
------------

// File: rtl/som_bmu_search_if.sv
// Bus between the SOM controller (master) and the best-matching-unit finder (slave).
// Carries the distance load, the per-stage compare strobes and the winner result.
interface som_bmu_search_if #(
  parameter int DW = 20,
  parameter int IW = 4
);
  logic               op_wr;
  logic [16*DW-1:0]   dist_in;
  logic [3:0]         compare_en;
  logic               bmu_valid;
  logic [IW-1:0]      bmu_idx;
  logic [DW-1:0]      bmu_dist;
  logic               busy;
  logic               seq_err;

  modport master (
    output op_wr, dist_in, compare_en,
    input  bmu_valid, bmu_idx, bmu_dist, busy, seq_err
  );

  modport slave (
    input  op_wr, dist_in, compare_en,
    output bmu_valid, bmu_idx, bmu_dist, busy, seq_err
  );
endinterface

// File: rtl/som_bmu_search.sv
// Best-matching-unit finder: latches 16 neuron distances, then reduces them with a
// 4-stage pairwise tournament (16->8->4->2->1), one stage per expected compare strobe.
// Ties resolve to the lower neuron index. Out-of-order strobes are ignored and flagged.
module som_bmu_search #(
  parameter int DW = 20,
  parameter int IW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  som_bmu_search_if.slave      bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      exp_stg_q, exp_stg_d;
  logic [DW-1:0]   cand_dist_q [16];
  logic [DW-1:0]   cand_dist_d [16];
  logic [IW-1:0]   cand_idx_q  [16];
  logic [IW-1:0]   cand_idx_d  [16];
  logic            bmu_valid_q, bmu_valid_d;
  logic [IW-1:0]   bmu_idx_q, bmu_idx_d;
  logic [DW-1:0]   bmu_dist_q, bmu_dist_d;
  logic            seq_err_q, seq_err_d;

  // Pair winners for every slot pair; only the low slots are meaningful in later stages.
  logic [DW-1:0]   win_dist [8];
  logic [IW-1:0]   win_idx  [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pair
      // Lower slot wins on equal distance, which keeps ties at the lower neuron index.
      assign win_dist[gi] = (cand_dist_q[2*gi] <= cand_dist_q[2*gi+1]) ?
                            cand_dist_q[2*gi] : cand_dist_q[2*gi+1];
      assign win_idx[gi]  = (cand_dist_q[2*gi] <= cand_dist_q[2*gi+1]) ?
                            cand_idx_q[2*gi]  : cand_idx_q[2*gi+1];
    end
  endgenerate

  // A strobe is accepted only when it equals the one-hot code of the expected stage;
  // this comparison also rejects any strobe that is not one-hot.
  logic       ce_nz;
  logic [3:0] ce_exp_code;
  logic       ce_expected;
  assign ce_nz       = |bus.compare_en;
  assign ce_exp_code = 4'b1000 >> exp_stg_q;
  assign ce_expected = (bus.compare_en == ce_exp_code);

  // Next-state: load has priority, then in-order stage reductions, else flag misuse.
  always_comb begin
    state_d     = state_q;
    exp_stg_d   = exp_stg_q;
    bmu_valid_d = 1'b0;
    bmu_idx_d   = bmu_idx_q;
    bmu_dist_d  = bmu_dist_q;
    seq_err_d   = seq_err_q;
    for (int k = 0; k < 16; k++) begin
      cand_dist_d[k] = cand_dist_q[k];
      cand_idx_d[k]  = cand_idx_q[k];
    end

    if (bus.op_wr) begin
      // Same-cycle strobe is silently dropped.
      for (int k = 0; k < 16; k++) begin
        cand_dist_d[k] = bus.dist_in[k*DW +: DW];
        cand_idx_d[k]  = IW'(k);
      end
      exp_stg_d = 2'd0;
      state_d   = RUN;
    end else if (ce_nz) begin
      if (state_q == RUN && ce_expected) begin
        for (int j = 0; j < 8; j++) begin
          cand_dist_d[j] = win_dist[j];
          cand_idx_d[j]  = win_idx[j];
        end
        exp_stg_d = exp_stg_q + 2'd1;
        if (exp_stg_q == 2'd3) begin
          bmu_valid_d = 1'b1;
          bmu_idx_d   = win_idx[0];
          bmu_dist_d  = win_dist[0];
          state_d     = IDLE;
        end
      end else begin
        seq_err_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset aborts any search in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      exp_stg_q   <= 2'd0;
      bmu_valid_q <= 1'b0;
      bmu_idx_q   <= '0;
      bmu_dist_q  <= '0;
      seq_err_q   <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        cand_dist_q[k] <= '0;
        cand_idx_q[k]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      exp_stg_q   <= exp_stg_d;
      bmu_valid_q <= bmu_valid_d;
      bmu_idx_q   <= bmu_idx_d;
      bmu_dist_q  <= bmu_dist_d;
      seq_err_q   <= seq_err_d;
      for (int k = 0; k < 16; k++) begin
        cand_dist_q[k] <= cand_dist_d[k];
        cand_idx_q[k]  <= cand_idx_d[k];
      end
    end
  end

  assign bus.bmu_valid = bmu_valid_q;
  assign bus.bmu_idx   = bmu_idx_q;
  assign bus.bmu_dist  = bmu_dist_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_som_bmu_search.sv
// Directed + randomized bench for som_bmu_search. The reference is a plain
// first-minimum scan over the 16 distances.
module tb_som_bmu_search;
  localparam int DW = 20;
  localparam int IW = 4;
  localparam logic [DW-1:0] DMAX = {DW{1'b1}};

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   prev_idx;
  int   prev_dist;

  som_bmu_search_if #(.DW(DW), .IW(IW)) bus_if ();

  som_bmu_search #(.DW(DW), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [DW-1:0] dvec_t [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Reference: index of the first (lowest-index) minimum distance.
  function automatic int ref_idx(input dvec_t d);
    int best;
    best = 0;
    for (int k = 1; k < 16; k++)
      if (d[k] < d[best]) best = k;
    return best;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dist(input dvec_t d);
    for (int k = 0; k < 16; k++) bus_if.dist_in[k*DW +: DW] = d[k];
  endtask

  task automatic load(input dvec_t d);
    drive_dist(d);
    bus_if.op_wr = 1'b1;
    tick();
    bus_if.op_wr = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] ce);
    bus_if.compare_en = ce;
    tick();
    bus_if.compare_en = 4'b0000;
  endtask

  // Run the 4 strobes (optionally with idle gaps) after a load already issued,
  // checking the held result meanwhile and the new winner at the end.
  task automatic finish_search(input string tag, input dvec_t d, input int gap_max);
    logic [3:0] ce;
    int e;
    e = ref_idx(d);
    for (int s = 0; s < 4; s++) begin
      repeat ($urandom_range(0, gap_max)) begin
        tick();
        check({tag, "_gap_valid"}, 32'(bus_if.bmu_valid), 32'd0);
      end
      ce = 4'b1000 >> s;
      strobe(ce);
      if (s < 3) begin
        check({tag, "_mid_valid"}, 32'(bus_if.bmu_valid), 32'd0);
        check({tag, "_mid_idx_held"}, 32'(bus_if.bmu_idx), 32'(prev_idx));
      end
    end
    check({tag, "_valid"}, 32'(bus_if.bmu_valid), 32'd1);
    check({tag, "_idx"},   32'(bus_if.bmu_idx),   32'(e));
    check({tag, "_dist"},  32'(bus_if.bmu_dist),  32'(d[e]));
    check({tag, "_busy"},  32'(bus_if.busy),      32'd0);
    $display("search %s: idx=%0d dist=%0d (ref idx=%0d dist=%0d)",
             tag, bus_if.bmu_idx, bus_if.bmu_dist, e, d[e]);
    prev_idx  = e;
    prev_dist = int'(d[e]);
    tick();
    check({tag, "_pulse_end"}, 32'(bus_if.bmu_valid), 32'd0);
    check({tag, "_idx_hold"},  32'(bus_if.bmu_idx),   32'(prev_idx));
  endtask

  task automatic run_search(input string tag, input dvec_t d, input int gap_max);
    load(d);
    check({tag, "_busy_load"}, 32'(bus_if.busy), 32'd1);
    finish_search(tag, d, gap_max);
  endtask

  dvec_t da, db;

  initial begin
    total = 0; bad = 0; prev_idx = 0; prev_dist = 0;
    rst = 1'b0;
    bus_if.op_wr = 1'b0;
    bus_if.compare_en = 4'b0000;
    bus_if.dist_in = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_valid", 32'(bus_if.bmu_valid), 32'd0);
    check("rst_idx",   32'(bus_if.bmu_idx),   32'd0);
    check("rst_dist",  32'(bus_if.bmu_dist),  32'd0);
    check("rst_busy",  32'(bus_if.busy),      32'd0);
    check("rst_err",   32'(bus_if.seq_err),   32'd0);

    // Single clear minimum.
    for (int k = 0; k < 16; k++) da[k] = DW'(100 + k);
    da[9] = DW'(3);
    run_search("single_min", da, 0);

    // Ties.
    for (int k = 0; k < 16; k++) da[k] = DW'(50);
    run_search("tie_all", da, 0);
    for (int k = 0; k < 16; k++) da[k] = DMAX;
    da[6] = DW'(7); da[13] = DW'(7);
    run_search("tie_6_13", da, 0);

    // Width edge.
    for (int k = 0; k < 16; k++) da[k] = DMAX;
    da[15] = DMAX - 1'b1;
    run_search("width_edge", da, 0);

    // Randomized: wide values, then narrow values to force ties, some with gaps.
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 16; k++)
        da[k] = (t < 4) ? DW'($urandom) : DW'($urandom_range(0, 5));
      run_search($sformatf("rand%0d", t), da, (t % 2 == 1) ? 3 : 0);
    end

    // Same data back-to-back then with gaps.
    for (int k = 0; k < 16; k++) da[k] = DW'($urandom);
    run_search("nogap", da, 0);
    run_search("gaps", da, 4);

    // Back-to-back: op_wr in the s3 cycle drops that strobe.
    for (int k = 0; k < 16; k++) da[k] = DW'($urandom);
    for (int k = 0; k < 16; k++) db[k] = DW'($urandom);
    load(da);
    strobe(4'b1000); strobe(4'b0100); strobe(4'b0010);
    drive_dist(db);
    bus_if.op_wr = 1'b1;
    bus_if.compare_en = 4'b0001;
    tick();
    bus_if.op_wr = 1'b0;
    bus_if.compare_en = 4'b0000;
    check("b2b_no_valid", 32'(bus_if.bmu_valid), 32'd0);
    check("b2b_idx_held", 32'(bus_if.bmu_idx),   32'(prev_idx));
    check("b2b_dist_held", 32'(bus_if.bmu_dist), 32'(prev_dist));
    check("b2b_busy",     32'(bus_if.busy),      32'd1);
    check("b2b_no_err",   32'(bus_if.seq_err),   32'd0);
    finish_search("b2b", db, 0);

    // Misorder: 0010 before 0100.
    for (int k = 0; k < 16; k++) da[k] = DW'($urandom);
    load(da);
    strobe(4'b1000);
    strobe(4'b0010);
    check("misorder_err",  32'(bus_if.seq_err), 32'd1);
    check("misorder_busy", 32'(bus_if.busy),    32'd1);
    strobe(4'b0100); strobe(4'b0010); strobe(4'b0001);
    check("misorder_valid", 32'(bus_if.bmu_valid), 32'd1);
    check("misorder_idx",   32'(bus_if.bmu_idx),   32'(ref_idx(da)));
    check("misorder_dist",  32'(bus_if.bmu_dist),  32'(da[ref_idx(da)]));
    $display("search misorder: idx=%0d", bus_if.bmu_idx);
    prev_idx = ref_idx(da);
    prev_dist = int'(da[prev_idx]);
    tick();

    // Reset mid-RUN: outputs clear immediately, no result afterwards.
    load(da);
    strobe(4'b1000); strobe(4'b0100);
    #2 rst = 1'b0;
    #1;
    check("arst_idx",  32'(bus_if.bmu_idx),  32'd0);
    check("arst_dist", 32'(bus_if.bmu_dist), 32'd0);
    check("arst_busy", 32'(bus_if.busy),     32'd0);
    check("arst_err",  32'(bus_if.seq_err),  32'd0);
    tick();
    rst = 1'b1;
    strobe(4'b0010);
    check("post_rst_valid", 32'(bus_if.bmu_valid), 32'd0);
    check("idle_strobe_err", 32'(bus_if.seq_err),  32'd1);
    strobe(4'b0001);
    check("post_rst_valid2", 32'(bus_if.bmu_valid), 32'd0);
    check("post_rst_idx",    32'(bus_if.bmu_idx),   32'd0);
    repeat (3) begin
      tick();
      check("post_rst_quiet", 32'(bus_if.bmu_valid), 32'd0);
    end

    // Non-one-hot strobe in RUN is flagged and ignored.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    prev_idx = 0; prev_dist = 0;
    for (int k = 0; k < 16; k++) da[k] = DW'($urandom);
    load(da);
    strobe(4'b1100);
    check("nonhot_err",  32'(bus_if.seq_err), 32'd1);
    check("nonhot_busy", 32'(bus_if.busy),    32'd1);
    finish_search("nonhot", da, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
